// File: rtl/sparc_ctrl_pipe.sv
// sparc_ctrl_pipe: SPARC V8 control decode feeding a short registered control
// pipeline with stall/flush, plus a counter of retired useful instructions.
module sparc_ctrl_pipe #(
  parameter int STAGES      = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [31:0]           instr,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  output logic [STAGES*19-1:0]  ctrl_out,
  output logic [STAGES-1:0]     valid_out,
  output logic [CNT_W-1:0]      retired_cnt
);

  localparam int B_ILLEGAL    = 18;
  localparam int B_CALL       = 17;
  localparam int B_BRANCH     = 16;
  localparam int B_JMPL       = 15;
  localparam int B_SETHI      = 14;
  localparam int B_LOAD       = 13;
  localparam int B_STORE      = 12;
  localparam int B_RF_LE      = 11;
  localparam int B_CC_WRITE   = 10;
  localparam int B_IMM        = 9;
  localparam int B_MEM_SIGNED = 8;
  localparam int B_ANNUL      = 1;
  localparam int B_NOP        = 0;

  logic [1:0]  op;
  logic [2:0]  op2;
  logic [5:0]  op3;
  logic [18:0] dec;

  logic [STAGES-1:0][18:0] stg_q, stg_d;
  logic [STAGES-1:0]       vld_q, vld_d;
  logic [18:0]             last_word;
  logic                    retire;

  assign op  = instr[31:30];
  assign op2 = instr[24:22];
  assign op3 = instr[24:19];

  // Combinational instruction decode into the 19-bit control word
  always_comb begin
    dec = '0;
    if (instr == 32'h0100_0000) begin
      dec[B_NOP] = 1'b1;
    end else begin
      case (op)
        2'b01: begin
          dec[B_CALL]  = 1'b1;
          dec[B_RF_LE] = 1'b1;
        end
        2'b00: begin
          if (op2 == 3'b100) begin
            dec[B_SETHI] = 1'b1;
            dec[B_RF_LE] = 1'b1;
          end else if (op2 == 3'b010) begin
            dec[B_BRANCH] = 1'b1;
            dec[B_ANNUL]  = instr[29];
          end else begin
            dec[B_ILLEGAL] = 1'b1;
          end
        end
        2'b10: begin
          if (!op3[5]) begin
            dec[5:2]        = op3[3:0];
            dec[B_CC_WRITE] = op3[4];
            dec[B_RF_LE]    = 1'b1;
            dec[B_IMM]      = instr[13];
          end else if (op3 == 6'b111000) begin
            dec[B_JMPL]  = 1'b1;
            dec[B_RF_LE] = 1'b1;
            dec[B_IMM]   = instr[13];
          end else begin
            dec[B_ILLEGAL] = 1'b1;
          end
        end
        default: begin
          dec[B_STORE]      = op3[2];
          dec[B_LOAD]       = ~op3[2];
          dec[B_RF_LE]      = ~op3[2];
          dec[B_IMM]        = instr[13];
          dec[B_MEM_SIGNED] = op3[3];
          case (op3[1:0])
            2'b01:   dec[7:6] = 2'b00;
            2'b10:   dec[7:6] = 2'b01;
            2'b00:   dec[7:6] = 2'b10;
            default: dec[7:6] = 2'b11;
          endcase
        end
      endcase
    end
  end

  // Next-state of every stage; flush overrides stall, squashed stages carry a zero word
  always_comb begin
    stg_d = stg_q;
    vld_d = vld_q;
    if (flush) begin
      stg_d[0] = '0;
      vld_d[0] = 1'b0;
    end else if (!stall) begin
      stg_d[0] = in_valid ? dec : '0;
      vld_d[0] = in_valid;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (flush && (k < FLUSH_DEPTH)) begin
        stg_d[k] = '0;
        vld_d[k] = 1'b0;
      end else if (!flush && stall && (k == 1)) begin
        stg_d[k] = '0;
        vld_d[k] = 1'b0;
      end else begin
        stg_d[k] = stg_q[k-1];
        vld_d[k] = vld_q[k-1];
      end
    end
  end

  // Pipeline stage registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stg_q <= '0;
      vld_q <= '0;
    end else begin
      stg_q <= stg_d;
      vld_q <= vld_d;
    end
  end

  assign last_word = stg_q[STAGES-1];
  assign retire    = vld_q[STAGES-1] & ~last_word[B_NOP] & ~last_word[B_ILLEGAL];

  // Count words leaving the last stage that did real work
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      retired_cnt <= '0;
    end else if (retire) begin
      retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  assign ctrl_out  = stg_q;
  assign valid_out = vld_q;

endmodule
